// File: rtl/modinv_seq_if.sv
// Request/result bundle for the modular-inverse engine.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while ready is high; the result is not held back.
//
// Ports (master = requester, slave = engine):
//   start, e, m              : request and its operands
//   ready, busy, done, valid : engine status and one-cycle completion pulse
//   d                        : result, held until the next done
interface modinv_seq_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] m;
   logic             ready;
   logic             busy;
   logic             done;
   logic             valid;
   logic [WIDTH-1:0] d;

   modport master (
      output start, e, m,
      input  ready, busy, done, valid, d
   );

   modport slave (
      input  start, e, m,
      output ready, busy, done, valid, d
   );
endinterface

// File: rtl/modinv_seq.sv
// Modular inverse d = e^-1 mod m via extended Euclid with a bit-serial restoring divider.
// Latency: done in cycle 2 + n*(WIDTH+2) after the start edge, n = nonzero-divisor iterations.
// Backpressure: start accepted only in IDLE (ready = 1); no queueing, results held until next done.
//
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-low reset
//   io       : slave side of modinv_seq_if (start/e/m in; ready/busy/done/valid/d out)
module modinv_seq #(
   parameter int WIDTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   modinv_seq_if.slave io
);
   localparam int KW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, CHECK, DIV, UPDATE, DONE} state_t;

   state_t                   state, state_nxt;
   logic [WIDTH-1:0]         r0, r1, rem, m_reg, d_reg;
   logic signed [WIDTH:0]    t0, t1, tacc;
   logic [KW-1:0]            k;
   logic                     valid_reg;

   logic [2*WIDTH-1:0]       div_sub;
   logic                     div_fit;
   logic signed [2*WIDTH:0]  t_shift;
   logic signed [WIDTH:0]    t_fix;
   logic                     finish;
   logic                     valid_calc;
   logic [WIDTH-1:0]         d_calc;

   always_comb begin
      // Trial subtrahend for the current quotient bit; the wide compare avoids
      // losing bits of r1 shifted past the top of the operand width.
      div_sub    = {{WIDTH{1'b0}}, r1} << k;
      div_fit    = (div_sub <= {{WIDTH{1'b0}}, rem});
      // |t| stays within m, so the low WIDTH+1 bits of the product are exact.
      t_shift    = $signed({{WIDTH{t1[WIDTH]}}, t1}) <<< k;
      t_fix      = t0 + $signed({1'b0, m_reg});
      finish     = (m_reg < WIDTH'(2)) || (r1 == '0);
      valid_calc = (r0 == WIDTH'(1)) && (m_reg >= WIDTH'(2));
      d_calc     = '0;
      if (valid_calc) begin
         d_calc = t0[WIDTH] ? t_fix[WIDTH-1:0] : t0[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (io.start) state_nxt = CHECK;
         CHECK:   state_nxt = finish ? DONE : DIV;
         DIV:     if (k == '0) state_nxt = UPDATE;
         UPDATE:  state_nxt = CHECK;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r0        <= '0;
         r1        <= '0;
         rem       <= '0;
         m_reg     <= '0;
         t0        <= '0;
         t1        <= '0;
         tacc      <= '0;
         k         <= '0;
         d_reg     <= '0;
         valid_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (io.start) begin
                  r0    <= io.m;
                  r1    <= io.e;
                  m_reg <= io.m;
                  t0    <= '0;
                  t1    <= (WIDTH+1)'(1);
               end
            end
            CHECK: begin
               // Results are registered on the way into DONE so they change
               // exactly in the cycle done is high.
               if (finish) begin
                  d_reg     <= d_calc;
                  valid_reg <= valid_calc;
               end else begin
                  rem  <= r0;
                  tacc <= t0;
                  k    <= KW'(WIDTH-1);
               end
            end
            DIV: begin
               if (div_fit) begin
                  rem  <= rem - div_sub[WIDTH-1:0];
                  tacc <= tacc - $signed(t_shift[WIDTH:0]);
               end
               k <= k - KW'(1);
            end
            UPDATE: begin
               r0 <= r1;
               r1 <= rem;
               t0 <= t1;
               t1 <= tacc;
            end
            default: ;
         endcase
      end
   end

   assign io.ready = (state == IDLE);
   assign io.busy  = (state == CHECK) || (state == DIV) || (state == UPDATE);
   assign io.done  = (state == DONE);
   assign io.valid = valid_reg;
   assign io.d     = d_reg;
endmodule

// File: tb/tb_modinv_seq.sv
// Self-checking bench for modinv_seq at WIDTH 16 and WIDTH 64.
// Latency checked per request against an extended-Euclid reference model.
// Requests queue expected results in a scoreboard, popped when done pulses.
module tb_modinv_seq;
   logic clk;
   logic rst;

   modinv_seq_if #(.WIDTH(16)) io16 ();
   modinv_seq_if #(.WIDTH(64)) io64 ();

   modinv_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .io(io16.slave));
   modinv_seq #(.WIDTH(64)) u64 (.clk(clk), .rst(rst), .io(io64.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          w;
      logic [63:0] e;
      logic [63:0] m;
      logic [63:0] d;
      logic        v;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [63:0] last_d16 = 0, last_d64 = 0;
   logic        last_v16 = 0, last_v64 = 0;

   function automatic logic [63:0] o_d(int w);
      return (w == 16) ? {48'd0, io16.d} : io64.d;
   endfunction
   function automatic logic o_valid(int w);
      return (w == 16) ? io16.valid : io64.valid;
   endfunction
   function automatic logic o_done(int w);
      return (w == 16) ? io16.done : io64.done;
   endfunction
   function automatic logic o_ready(int w);
      return (w == 16) ? io16.ready : io64.ready;
   endfunction
   function automatic logic o_busy(int w);
      return (w == 16) ? io16.busy : io64.busy;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic set_in(int w, logic s, logic [63:0] e, logic [63:0] m);
      if (w == 16) begin
         io16.start = s; io16.e = e[15:0]; io16.m = m[15:0];
      end else begin
         io64.start = s; io64.e = e; io64.m = m;
      end
   endtask

   // Reference: plain extended Euclid with true division, wide signed cofactors.
   task automatic model(input logic [63:0] e, input logic [63:0] m,
                        output logic [63:0] d, output logic v, output int n);
      logic [63:0]         r0, r1, q, rr;
      logic signed [129:0] t0, t1, tn;
      r0 = m; r1 = e; t0 = 0; t1 = 1; n = 0; d = 0; v = 0;
      if (m >= 2) begin
         while (r1 != 0) begin
            q  = r0 / r1;
            rr = r0 % r1;
            tn = t0 - $signed({66'd0, q}) * t1;
            r0 = r1; r1 = rr; t0 = t1; t1 = tn;
            n++;
         end
         v = (r0 == 1);
         if (v) d = (t0 < 0) ? 64'(t0 + $signed({66'd0, m})) : 64'(t0);
      end
   endtask

   // Issue a request once ready; the start edge is the following posedge.
   task automatic start_op(int w, logic [63:0] e, logic [63:0] m, bit push);
      exp_t x;
      int   n, guard;
      guard = 0;
      @(negedge clk);
      while (!o_ready(w) && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      x.w = w; x.e = e; x.m = m;
      model(e, m, x.d, x.v, n);
      x.cyc = 2 + n * (w + 2);
      set_in(w, 1'b1, e, m);
      if (push) sb.push_back(x);
      @(posedge clk);
      #1;
      set_in(w, 1'b0, 64'd0, 64'd0);
   endtask

   // Count cycles from the start edge until done; optionally pulse a stray
   // start mid-computation. Then compare against the scoreboard head.
   task automatic wait_done(int w, int poke_at, logic [63:0] pe, logic [63:0] pm);
      exp_t x;
      int   cyc;
      bit   held_ok;
      cyc = 1;
      held_ok = 1;
      x = sb.pop_front();
      while (!o_done(w) && cyc < 12000) begin
         if (o_d(w) !== (w == 16 ? last_d16 : last_d64) ||
             o_valid(w) !== (w == 16 ? last_v16 : last_v64)) held_ok = 0;
         if (cyc == poke_at) set_in(w, 1'b1, pe, pm);
         if (cyc == poke_at + 1) set_in(w, 1'b0, 64'd0, 64'd0);
         @(posedge clk);
         #1;
         cyc++;
      end
      set_in(w, 1'b0, 64'd0, 64'd0);
      if (!o_done(w)) begin
         checks++;
         errors++;
         $display("FAIL timeout w=%0d e=%0d m=%0d: no done within %0d cycles", w, x.e, x.m, cyc);
         return;
      end
      chk($sformatf("cycle w=%0d e=%0d m=%0d", w, x.e, x.m), 64'(cyc), 64'(x.cyc));
      chk($sformatf("d w=%0d e=%0d m=%0d", w, x.e, x.m), o_d(w), x.d);
      chk($sformatf("valid w=%0d e=%0d m=%0d", w, x.e, x.m), 64'(o_valid(w)), 64'(x.v));
      chk($sformatf("hold w=%0d e=%0d m=%0d", w, x.e, x.m), 64'(held_ok), 64'd1);
      if (w == 16) begin last_d16 = x.d; last_v16 = x.v; end
      else         begin last_d64 = x.d; last_v64 = x.v; end
   endtask

   task automatic run(int w, logic [63:0] e, logic [63:0] m);
      start_op(w, e, m, 1'b1);
      wait_done(w, -1, 64'd0, 64'd0);
   endtask

   initial begin
      logic [63:0] re, rm;
      rst = 1'b0;
      set_in(16, 1'b0, 64'd0, 64'd0);
      set_in(64, 1'b0, 64'd0, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst ready16", 64'(io16.ready), 64'd1);
      chk("rst busy16",  64'(io16.busy),  64'd0);
      chk("rst done16",  64'(io16.done),  64'd0);
      chk("rst valid16", 64'(io16.valid), 64'd0);
      chk("rst d16",     o_d(16),         64'd0);
      chk("rst ready64", 64'(io64.ready), 64'd1);
      chk("rst d64",     io64.d,          64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Main example with explicit ready-after-done and busy checks.
      start_op(16, 64'd3, 64'd20, 1'b1);
      chk("busy cycle1", 64'(io16.busy), 64'd1);
      wait_done(16, -1, 64'd0, 64'd0);
      chk("busy in done", 64'(io16.busy), 64'd0);
      @(posedge clk);
      #1;
      chk("ready after done", 64'(io16.ready), 64'd1);
      chk("done one pulse",   64'(io16.done),  64'd0);

      // Back-to-back request in the cycle after done.
      start_op(16, 64'd17, 64'd3120, 1'b1);
      wait_done(16, -1, 64'd0, 64'd0);
      chk("17*d mod 3120", (64'd17 * o_d(16)) % 64'd3120, 64'd1);

      run(16, 64'd6, 64'd9);
      run(16, 64'd5, 64'd9);
      run(16, 64'd3, 64'd20);
      run(16, 64'd6, 64'd9);

      // Corner cases.
      run(16, 64'd5, 64'd1);
      run(16, 64'd5, 64'd0);
      run(16, 64'd0, 64'd7);
      run(16, 64'd25, 64'd7);
      run(16, 64'd65535, 64'd65534);

      // Stray start during DIV must not disturb the running computation.
      start_op(16, 64'd3, 64'd20, 1'b1);
      wait_done(16, 5, 64'd17, 64'd3120);
      @(posedge clk);
      #1;
      chk("ready after stray", 64'(io16.ready), 64'd1);

      // Reset mid-DIV.
      start_op(16, 64'd17, 64'd3120, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      chk("busy mid div", 64'(io16.busy), 64'd1);
      rst = 1'b0;
      #1;
      chk("arst ready", 64'(io16.ready), 64'd1);
      chk("arst busy",  64'(io16.busy),  64'd0);
      chk("arst valid", 64'(io16.valid), 64'd0);
      chk("arst d",     o_d(16),         64'd0);
      chk("arst d64",   io64.d,          64'd0);
      last_d16 = 0; last_v16 = 0; last_d64 = 0; last_v64 = 0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("ready after arst", 64'(io16.ready), 64'd1);
      chk("done after arst",  64'(io16.done),  64'd0);
      run(16, 64'd5, 64'd9);

      // 64-bit: extremes, small random and full-width random pairs.
      run(64, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
      run(64, 64'd65537, 64'hFFFF_FFFF_FFFF_FFFF);
      run(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1000);
      for (int i = 0; i < 10; i++) begin
         rm = 64'($urandom_range(0, 1000));
         re = 64'($urandom_range(0, 2000));
         run(64, re, rm);
      end
      for (int i = 0; i < 10; i++) begin
         rm = {$urandom(), $urandom()};
         re = {$urandom(), $urandom()} | 64'd1;
         run(64, re, rm);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
